spi_xfer_sequencer: RTL
=======================

# spi_xfer_sequencer

Sequences full-duplex SPI byte transfers between the USB control endpoint's 32-byte OUT/IN buffers and the external SPI flash. On a start command it asserts chip select and shifts `len` bytes out of the TX buffer, one per byte slot, MSB first. It writes every received byte into the RX buffer at the same index, then releases chip select unless it was told to keep it asserted for a chained transfer. The block replaces the free-running divider/shift logic in the endpoint, which then only issues commands and waits for `done`.

## Interface
- `CLK_DIV`, default 4: SPI half-period in `clk` cycles; legal values 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle command strobe; sampled only in IDLE.
- `len`  in  6  byte count, 0..32; captured on accepted `start`.
- `keep_cs`  in  1  when 1, leave `spi_csn` low after the transfer; captured on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `tx_addr`  out  5  TX buffer read index; TX buffer is combinational read.
- `tx_data`  in  8  TX byte at `tx_addr`, valid in the same cycle.
- `rx_we`  out  1  RX buffer write strobe, one cycle per byte.
- `rx_addr`  out  5  RX buffer write index.
- `rx_data`  out  8  received byte.
- `spi_clk`  out  1  SPI clock; idles high (mode 3).
- `spi_csn`  out  1  chip select, active-low.
- `spi_mosi`  out  1  serial data to flash.
- `spi_miso`  in  1  serial data from flash.

## Operation
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, FINISH.
- **IDLE**
  - `start` with `len`=0: go to FINISH with no SPI activity; `spi_csn` keeps its current value.
  - `start` with `len`≠0: capture `len` and `keep_cs`, clear byte index `idx`, go to CS_SETUP.
- **CS_SETUP**
  - `spi_csn`=0 for one half-period (`CLK_DIV` cycles), then go to SHIFT.
  - `spi_clk` stays 1.
- **SHIFT**, per bit, 8 bits per byte:
  - Falling edge: `spi_clk` goes 1->0 and `spi_mosi` takes the current bit.
  - One half-period later, rising edge: `spi_clk` goes 0->1 and `spi_miso` is sampled into the shift register.
  - Next half-period: next falling edge.
- Byte load:
  - At the falling edge of bit 7 (MSB), `tx_data` at `tx_addr`=`idx` is loaded into the TX shift register.
  - The MSB is driven immediately; bits 6..0 follow on later falling edges.
- Byte completion:
  - At the rising edge of bit 0, `rx_we`=1 for one cycle, with `rx_addr`=`idx` and `rx_data`=assembled byte including that final sample.
  - `idx` then increments.
  - If `idx`+1 equals `len`, go to CS_HOLD instead of starting another byte.
- **CS_HOLD**
  - One half-period with `spi_clk`=1 and `spi_csn`=0.
  - Then `spi_csn` := `keep_cs` ? 0 : 1, and go to FINISH.
- **FINISH**
  - `done`=1 for one cycle, `busy`=0, then return to IDLE.
- A `start` seen outside IDLE is ignored and not queued.
- With chained transfers (`keep_cs`=1), the next `start` goes through CS_SETUP again. `spi_csn` is already 0, so only the setup delay applies.
- `idx` is 6 bits wide; `tx_addr` and `rx_addr` are `idx[4:0]`. `len`=32 therefore uses indices 0..31 with no wrap.
- `len` > 32 is illegal. The block truncates it to `len[5:0]` clamped to 32.
- Reset, including in the middle of a transfer, takes effect in the same clock edge and forces:
  - state to IDLE;
  - `spi_csn`=1, `spi_clk`=1, `spi_mosi`=0;
  - `busy`=0, `done`=0, `rx_we`=0;
  - `tx_addr`=0, `rx_addr`=0, `rx_data`=0.
  
  A partially shifted byte is not written to the RX buffer.

## Timing
- A half-period is a counter of `CLK_DIV` cycles, reloaded at every edge and at every state entry.
- Call the cycle where `start` is sampled cycle 0.
  - Cycle 1: `busy`=1 and `spi_csn`=0.
  - Cycle 1+`CLK_DIV`: first falling edge of `spi_clk`.
  - Each byte takes 16·`CLK_DIV` cycles.
  - `rx_we` for byte k is in cycle 1+`CLK_DIV`·(2+16k+15).
  - `done` is in cycle 1+`CLK_DIV`·(16·`len`+2).
- For `len`=0, `done` is in cycle 1.
- `spi_mosi` is stable for at least `CLK_DIV` cycles before and after each rising edge.
- All outputs are registered, with no combinational path from inputs to SPI pins.

## Test plan
1. **Single byte.** `CLK_DIV`=1, `len`=1, TX[0]=0xA5, miso loopback from mosi.
   - mosi bits are 1,0,1,0,0,1,0,1.
   - One `rx_we` with `rx_addr`=0 and `rx_data`=0xA5.
   - `done` at cycle 19; `spi_csn` returns to 1.
2. **Full buffer.** `CLK_DIV`=4, `len`=32, TX[k]=k, flash model returns ~k.
   - 32 `rx_we` strobes with addresses 0..31 and data 0xFF-k.
   - `done` at cycle 1+4·514=2057.
3. **Chained transfer.** `keep_cs`=1 with `len`=4, then `keep_cs`=0 with `len`=2.
   - `spi_csn` stays 0 across both transfers; no `spi_clk` activity between them.
   - `spi_csn`=1 after the second `done`.
4. **Zero length.** `len`=0.
   - `done` at cycle 1; no `spi_clk` or `spi_csn` toggling; no `rx_we`.
5. **Busy rejection.** `start` pulsed during SHIFT.
   - Ignored: transfer count and the timing of `done` are unchanged.
6. **Reset mid-transfer.** Reset during bit 3 of byte 2.
   - Next cycle: `spi_csn`=1, `spi_clk`=1, `busy`=0.
   - No `rx_we` for byte 2.
   - A subsequent `start` works normally.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// Full-duplex SPI (mode 3) byte sequencer between the control endpoint's
// 32-byte TX/RX buffers and the external flash.
//
// state      | meaning
// IDLE       | waiting for start; spi_csn holds its last value
// CS_SETUP   | spi_csn low, one half-period before the first falling edge
// SHIFT      | toggling spi_clk, 8 bits per byte, MSB first
// CS_HOLD    | one half-period with spi_clk high after the last byte
// FINISH     | one-cycle done pulse, then back to IDLE
module spi_xfer_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] len,
  input  logic       keep_cs,
  output logic       busy,
  output logic       done,
  output logic [4:0] tx_addr,
  input  logic [7:0] tx_data,
  output logic       rx_we,
  output logic [4:0] rx_addr,
  output logic [7:0] rx_data,
  output logic       spi_clk,
  output logic       spi_csn,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_CS_HOLD  = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [2:0] bit_cnt;
  logic [5:0] idx;
  logic [5:0] len_q;
  logic       keep_q;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;

  logic       half_done;
  logic [5:0] len_clamped;
  logic [5:0] idx_inc;
  logic       last_byte;

  assign half_done   = (cnt == 8'd0);
  // Anything above 32 is illegal; clamp so indices never wrap.
  assign len_clamped = len[5] ? 6'd32 : len;
  assign idx_inc     = idx + 6'd1;
  assign last_byte   = (idx_inc == len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      bit_cnt  <= 3'd0;
      idx      <= 6'd0;
      len_q    <= 6'd0;
      keep_q   <= 1'b0;
      tx_sr    <= 8'd0;
      rx_sr    <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_addr  <= 5'd0;
      rx_we    <= 1'b0;
      rx_addr  <= 5'd0;
      rx_data  <= 8'd0;
      spi_clk  <= 1'b1;
      spi_csn  <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      rx_we <= 1'b0;
      done  <= 1'b0;
      if (!half_done) cnt <= cnt - 8'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (len_clamped == 6'd0) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              len_q   <= len_clamped;
              keep_q  <= keep_cs;
              idx     <= 6'd0;
              tx_addr <= 5'd0;
              busy    <= 1'b1;
              spi_csn <= 1'b0;
              cnt     <= HALF_RELOAD;
              state   <= S_CS_SETUP;
            end
          end
        end

        S_CS_SETUP: begin
          if (half_done) begin
            cnt      <= HALF_RELOAD;
            spi_clk  <= 1'b0;
            spi_mosi <= tx_data[7];
            tx_sr    <= {tx_data[6:0], 1'b0};
            bit_cnt  <= 3'd7;
            state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (half_done) begin
            cnt <= HALF_RELOAD;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
              rx_sr   <= {rx_sr[6:0], spi_miso};
              // Point at the next TX byte early so it is valid at the next load.
              if (bit_cnt == 3'd0) tx_addr <= idx[4:0] + 5'd1;
            end else if (bit_cnt == 3'd0) begin
              rx_we   <= 1'b1;
              rx_addr <= idx[4:0];
              rx_data <= rx_sr;
              idx     <= idx_inc;
              if (last_byte) begin
                state <= S_CS_HOLD;
              end else begin
                spi_clk  <= 1'b0;
                spi_mosi <= tx_data[7];
                tx_sr    <= {tx_data[6:0], 1'b0};
                bit_cnt  <= 3'd7;
              end
            end else begin
              spi_clk  <= 1'b0;
              spi_mosi <= tx_sr[7];
              tx_sr    <= {tx_sr[6:0], 1'b0};
              bit_cnt  <= bit_cnt - 3'd1;
            end
          end
        end

        S_CS_HOLD: begin
          if (half_done) begin
            spi_csn <= ~keep_q;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_FINISH;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
